// File: rtl/i_tlc_if.sv
// rtl/i_tlc_if.sv - Sensor and lamp bundle between the crossing controller and its environment
interface i_tlc_if;
    logic       sensor;
    logic [2:0] M;
    logic [2:0] S;

    modport master (
        input  sensor,
        output M,
        output S
    );

    modport slave (
        output sensor,
        input  M,
        input  S
    );
endinterface

// File: rtl/i_tlc.sv
// rtl/i_tlc.sv - Main/side road traffic-light controller; optional all-red clearance via ITLC_ALL_RED_EN
module i_tlc #(
    parameter int MAIN_MIN_GREEN = 4,
    parameter int YELLOW_TIME    = 3,
    parameter int SIDE_MAX_GREEN = 5,
    parameter int ALL_RED_TIME   = 1,
    parameter int TW             = 8
) (
    input  logic      clock,
    input  logic      reset,
    i_tlc_if.master   bus
);

    localparam int MAX_PARAM_A = (MAIN_MIN_GREEN > YELLOW_TIME) ? MAIN_MIN_GREEN : YELLOW_TIME;
    localparam int MAX_PARAM_B = (SIDE_MAX_GREEN > ALL_RED_TIME) ? SIDE_MAX_GREEN : ALL_RED_TIME;
    localparam int MAX_PARAM   = (MAX_PARAM_A > MAX_PARAM_B) ? MAX_PARAM_A : MAX_PARAM_B;

    if (MAIN_MIN_GREEN < 1 || YELLOW_TIME < 1 || SIDE_MAX_GREEN < 1 || ALL_RED_TIME < 1
        || (MAX_PARAM - 1) >= (2 ** TW)) begin : g_bad_param
        $error("i_tlc: timing parameter out of range for timer width");
    end

    localparam logic [TW-1:0] MG_LAST = TW'(MAIN_MIN_GREEN - 1);
    localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] SG_LAST = TW'(SIDE_MAX_GREEN - 1);
`ifdef ITLC_ALL_RED_EN
    localparam logic [TW-1:0] AR_LAST = TW'(ALL_RED_TIME - 1);
`endif

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

`ifdef ITLC_ALL_RED_EN
    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_SG  = 3'd2,
        ST_SY  = 3'd3,
        ST_AR1 = 3'd4,
        ST_AR2 = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_SG  = 3'd2,
        ST_SY  = 3'd3
    } state_t;
`endif

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_MG;
        end else begin
            state_q <= state_d;
        end
    end

    // Dwell timer: restarts at every state change and sticks at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (timer_q != {TW{1'b1}}) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Next-state logic; sensor matters only in the two green states
    always_comb begin
        state_d = ST_MG;
        case (state_q)
            ST_MG: begin
                if (bus.sensor && (timer_q >= MG_LAST)) state_d = ST_MY;
                else                                      state_d = ST_MG;
            end
            ST_MY: begin
`ifdef ITLC_ALL_RED_EN
                state_d = (timer_q == Y_LAST) ? ST_AR1 : ST_MY;
`else
                state_d = (timer_q == Y_LAST) ? ST_SG : ST_MY;
`endif
            end
`ifdef ITLC_ALL_RED_EN
            ST_AR1: state_d = (timer_q == AR_LAST) ? ST_SG : ST_AR1;
            ST_AR2: state_d = (timer_q == AR_LAST) ? ST_MG : ST_AR2;
`endif
            ST_SG: begin
                // A vacated side road is only believed after the first green cycle
                if ((!bus.sensor && (timer_q != '0)) || (timer_q == SG_LAST)) state_d = ST_SY;
                else                                                             state_d = ST_SG;
            end
            ST_SY: begin
`ifdef ITLC_ALL_RED_EN
                state_d = (timer_q == Y_LAST) ? ST_AR2 : ST_SY;
`else
                state_d = (timer_q == Y_LAST) ? ST_MG : ST_SY;
`endif
            end
            default: state_d = ST_MG;
        endcase
    end

    // Lamp decode from registered state only; unknown encodings show all-red
    always_comb begin
        bus.M = LAMP_R;
        bus.S = LAMP_R;
        case (state_q)
            ST_MG: begin bus.M = LAMP_G; bus.S = LAMP_R; end
            ST_MY: begin bus.M = LAMP_Y; bus.S = LAMP_R; end
            ST_SG: begin bus.M = LAMP_R; bus.S = LAMP_G; end
            ST_SY: begin bus.M = LAMP_R; bus.S = LAMP_Y; end
            default: begin bus.M = LAMP_R; bus.S = LAMP_R; end
        endcase
    end

endmodule

// File: tb/tb_i_tlc.sv
// tb/tb_i_tlc.sv - Table-driven and randomized self-checking bench for i_tlc
module tb_i_tlc;
    localparam int MAIN_MIN_GREEN = 4;
    localparam int YELLOW_TIME    = 3;
    localparam int SIDE_MAX_GREEN = 5;
    localparam int ALL_RED_TIME   = 1;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    i_tlc_if bus ();

    i_tlc #(
        .MAIN_MIN_GREEN(MAIN_MIN_GREEN),
        .YELLOW_TIME   (YELLOW_TIME),
        .SIDE_MAX_GREEN(SIDE_MAX_GREEN),
        .ALL_RED_TIME  (ALL_RED_TIME),
        .TW            (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    // Reference model: a list of phases walked in order, each with its own exit rule
    typedef enum int {P_MG, P_MY, P_AR1, P_SG, P_SY, P_AR2} phase_t;
    phase_t ring[$];
    int     ring_pos;
    int     age;

    function automatic phase_t cur_phase();
        return ring[ring_pos];
    endfunction

    function automatic logic [5:0] lamps(phase_t p);
        case (p)
            P_MG:    return {G, R};
            P_MY:    return {Y, R};
            P_SG:    return {R, G};
            P_SY:    return {R, Y};
            default: return {R, R};
        endcase
    endfunction

    task automatic model_reset();
        ring = {P_MG, P_MY};
`ifdef ITLC_ALL_RED_EN
        ring.push_back(P_AR1);
`endif
        ring.push_back(P_SG);
        ring.push_back(P_SY);
`ifdef ITLC_ALL_RED_EN
        ring.push_back(P_AR2);
`endif
        ring_pos = 0;
        age = 0;
    endtask

    task automatic model_step(input bit sen);
        bit leave;
        case (cur_phase())
            P_MG:         leave = sen && (age + 1 >= MAIN_MIN_GREEN);
            P_MY, P_SY:   leave = (age + 1 == YELLOW_TIME);
            P_AR1, P_AR2: leave = (age + 1 == ALL_RED_TIME);
            P_SG:         leave = (!sen && age > 0) || (age + 1 == SIDE_MAX_GREEN);
            default:      leave = 1'b1;
        endcase
        if (leave) begin
            ring_pos = (ring_pos + 1) % ring.size();
            age = 0;
        end else begin
            age++;
        end
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_invariant(input string tag);
        checks++;
        if ((bus.M !== R && bus.S !== R) || (bus.M === G && bus.S === G)) begin
            failures++;
            $display("FAIL %s_invariant: got M=%b S=%b expected at least one red", tag, bus.M, bus.S);
        end
    endtask

    // One controller cycle: drive sensor, sample mid-cycle, then let the edge pass
    task automatic cyc(input bit sen, input string tag);
        logic [5:0] e;
        bus.sensor = sen;
        @(negedge clock);
        e = lamps(cur_phase());
        chk({tag, "_M"}, bus.M, e[5:3]);
        chk({tag, "_S"}, bus.S, e[2:0]);
        chk_invariant(tag);
        @(posedge clock);
        #1;
        model_step(sen);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        bus.sensor = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk({tag, "_rst_M"}, bus.M, G);
        chk({tag, "_rst_S"}, bus.S, R);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         sensor;
        logic [2:0] m;
        logic [2:0] s;
    } vec_t;

    vec_t vecs[20];

    initial begin
        bus.sensor = 1'b0;
        model_reset();

`ifndef ITLC_ALL_RED_EN
        begin
            int seg_len[6];
            logic [5:0] seg_lamp[6];
            int k;
            seg_len  = '{4, 3, 5, 3, 4, 1};
            seg_lamp = '{{G, R}, {Y, R}, {R, G}, {R, Y}, {G, R}, {Y, R}};
            k = 0;
            for (int g = 0; g < 6; g++)
                for (int j = 0; j < seg_len[g]; j++) begin
                    vecs[k] = '{1'b1, seg_lamp[g][5:3], seg_lamp[g][2:0]};
                    k++;
                end
        end
`endif

        // Idle main green with no side traffic
        do_reset("idle");
        for (int i = 0; i < 20; i++) cyc(1'b0, "idle");

`ifndef ITLC_ALL_RED_EN
        // Continuous demand: fixed expected lamp sequence
        do_reset("tab");
        for (int i = 0; i < 20; i++) begin
            bus.sensor = vecs[i].sensor;
            @(negedge clock);
            chk($sformatf("tab%0d_M", i), bus.M, vecs[i].m);
            chk($sformatf("tab%0d_S", i), bus.S, vecs[i].s);
            chk_invariant("tab");
            @(posedge clock);
            #1;
        end
`endif

        // Side traffic leaves two cycles into side green
        do_reset("leave");
        begin
            int sg_len;
            bit seen_sg;
            sg_len = 0;
            seen_sg = 1'b0;
            for (int i = 0; i < 30; i++) begin
                bit sen;
                sen = !(seen_sg && sg_len >= 2);
                if (cur_phase() == P_SG) begin
                    seen_sg = 1'b1;
                    sg_len++;
                end
                cyc(sen, "leave");
            end
        end

        // Single short pulse while main green is still inside its minimum
        do_reset("pulse");
        cyc(1'b0, "pulse");
        cyc(1'b1, "pulse");
        for (int i = 0; i < 10; i++) cyc(1'b0, "pulse");
        @(negedge clock);
        chk("pulse_hold_M", bus.M, G);

        // Asynchronous reset while side green
        do_reset("async");
        for (int i = 0; i < 40 && cur_phase() != P_SG; i++) cyc(1'b1, "async");
        cyc(1'b1, "async");
        chk("async_pre_S", bus.S, G);
        #2;
        reset = 1'b0;
        #1;
        chk("async_M", bus.M, G);
        chk("async_S", bus.S, R);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 25; i++) cyc(1'b1, "after_async");

        // Randomized demand patterns with runs of varying length
        do_reset("rand");
        begin
            bit sen;
            int run;
            sen = 1'b0;
            run = 0;
            for (int i = 0; i < 600; i++) begin
                if (run == 0) begin
                    sen = $urandom_range(0, 1) != 0;
                    run = $urandom_range(1, 9);
                end
                run--;
                cyc(sen, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected completion within bound");
        $fatal(1, "timeout");
    end
endmodule
